// File: rtl/tholin_namebadge.sv
`default_nettype none
// ============================================================================
// tholin_namebadge - HD44780 4-bit LCD name badge with periodic effects | rev 1.0
// ============================================================================
module tholin_namebadge #(
  parameter int POWERUP_CYCLES    = 500,
  parameter int INIT_WAIT_CYCLES  = 50,
  parameter int BYTE_WAIT_CYCLES  = 2,
  parameter int CLEAR_WAIT_CYCLES = 30,
  parameter int TICK_CYCLES       = 5000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int c_max_a   = (POWERUP_CYCLES > TICK_CYCLES) ? POWERUP_CYCLES : TICK_CYCLES;
  localparam int c_max_b   = (INIT_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? INIT_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int c_max_c   = (c_max_b > BYTE_WAIT_CYCLES) ? c_max_b : BYTE_WAIT_CYCLES;
  localparam int c_cnt_max = (c_max_a > c_max_c) ? c_max_a : c_max_c;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_power_last = c_cnt_w'(POWERUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_init_last  = c_cnt_w'(INIT_WAIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_byte_last  = c_cnt_w'(BYTE_WAIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_clear_last = c_cnt_w'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_tick_last  = c_cnt_w'(TICK_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  localparam logic [5:0]   c_last_step = 6'd41;
  localparam logic [127:0] c_msg_top   = "  HELLO, I AM   ";
  localparam logic [127:0] c_msg_bot   = "     THOLIN     ";

  typedef enum logic [2:0] {
    S_POWER  = 3'd0,
    S_C0     = 3'd1,
    S_C1     = 3'd2,
    S_C2     = 3'd3,
    S_WAIT   = 3'd4,
    S_IDLE   = 3'd5,
    S_EFFECT = 3'd6
  } state_t;

  logic w_clk;
  logic w_rst;
  logic [1:0] w_mode;
  logic w_unused_pins;

  assign w_clk         = io_in[0];
  assign w_rst         = io_in[1];
  assign w_mode        = io_in[3:2];
  assign w_unused_pins = ^io_in[7:4];

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]         r_step, w_step_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_single, w_single_nxt;
  logic               r_half, w_half_nxt;
  logic               r_fx, w_fx_nxt;
  logic [7:0]         r_pend, w_pend_nxt;
  logic               r_pend_vld, w_pend_vld_nxt;
  logic               r_disp_on, w_disp_nxt;
  logic               r_rs, w_rs_nxt;
  logic               r_e, w_e_nxt;
  logic [3:0]         r_dout, w_dout_nxt;
  logic               r_led0, w_led0_nxt;
  logic               r_led1, w_led1_nxt;

  logic               w_start;
  logic [9:0]         w_ld;
  logic [7:0]         w_act;
  logic               w_act_vld;
  logic [c_cnt_w-1:0] w_wait_last;

  // Entry layout: {single-nibble, RS, byte}; single nibbles live in byte[7:4].
  function automatic logic [9:0] seq_entry(input logic [5:0] step);
    logic [9:0] ent;
    int         idx;
    ent = 10'h000;
    idx = 0;
    case (step)
      6'd0, 6'd1, 6'd2: ent = {2'b10, 8'h30};
      6'd3:             ent = {2'b10, 8'h20};
      6'd4:             ent = {2'b00, 8'h28};
      6'd5:             ent = {2'b00, 8'h0C};
      6'd6:             ent = {2'b00, 8'h06};
      6'd7:             ent = {2'b00, 8'h01};
      6'd8:             ent = {2'b00, 8'h80};
      6'd25:            ent = {2'b00, 8'hC0};
      default: begin
        if (step <= 6'd24) begin
          idx = int'(step) - 9;
          ent = {2'b01, c_msg_top[8*(15-idx) +: 8]};
        end else if (step <= c_last_step) begin
          idx = int'(step) - 26;
          ent = {2'b01, c_msg_bot[8*(15-idx) +: 8]};
        end
      end
    endcase
    return ent;
  endfunction

  // The clear command needs the long settle; wake-up nibbles use the init wait.
  assign w_wait_last = r_single ? c_init_last :
                       (!r_rs && (r_byte == 8'h01)) ? c_clear_last : c_byte_last;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = r_step;
    w_byte_nxt     = r_byte;
    w_single_nxt   = r_single;
    w_half_nxt     = r_half;
    w_fx_nxt       = r_fx;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_disp_nxt     = r_disp_on;
    w_rs_nxt       = r_rs;
    w_e_nxt        = 1'b0;
    w_dout_nxt     = r_dout;
    w_led0_nxt     = r_led0;
    w_led1_nxt     = r_led1;
    w_start        = 1'b0;
    w_ld           = 10'h000;
    w_act          = 8'h00;
    w_act_vld      = 1'b0;

    case (r_state)
      S_POWER: begin
        if (r_cnt == c_power_last) begin
          w_cnt_nxt  = '0;
          w_step_nxt = 6'd0;
          w_start    = 1'b1;
          w_ld       = seq_entry(6'd0);
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_C0: begin
        w_state_nxt = S_C1;
        w_e_nxt     = 1'b1;
      end
      S_C1: begin
        w_state_nxt = S_C2;
      end
      S_C2: begin
        if (!r_single && !r_half) begin
          w_state_nxt = S_C0;
          w_half_nxt  = 1'b1;
          w_dout_nxt  = r_byte[3:0];
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt == w_wait_last) begin
          w_cnt_nxt = '0;
          if (r_fx) begin
            if (r_pend_vld) begin
              w_pend_vld_nxt = 1'b0;
              w_start        = 1'b1;
              w_ld           = {2'b00, r_pend};
            end else begin
              w_fx_nxt    = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end else if (r_step == c_last_step) begin
            w_state_nxt = S_IDLE;
            w_led0_nxt  = 1'b1;
            w_disp_nxt  = 1'b1;
          end else begin
            w_step_nxt = r_step + 6'd1;
            w_start    = 1'b1;
            w_ld       = seq_entry(r_step + 6'd1);
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_IDLE: begin
        if (r_cnt == c_tick_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EFFECT;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_EFFECT: begin
        w_led1_nxt  = ~r_led1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
        case (w_mode)
          2'b01:   w_act = 8'h18;
          2'b10:   w_act = r_disp_on ? 8'h08 : 8'h0C;
          2'b11:   w_act = 8'h1C;
          default: w_act = 8'h00;
        endcase
        w_act_vld = (w_mode != 2'b00);
        // A blank display left behind by blink is restored before any other mode acts.
        if ((w_mode != 2'b10) && !r_disp_on) begin
          w_disp_nxt     = 1'b1;
          w_fx_nxt       = 1'b1;
          w_start        = 1'b1;
          w_ld           = {2'b00, 8'h0C};
          w_pend_nxt     = w_act;
          w_pend_vld_nxt = w_act_vld;
        end else if (w_act_vld) begin
          w_fx_nxt = 1'b1;
          w_start  = 1'b1;
          w_ld     = {2'b00, w_act};
          if (w_mode == 2'b10) begin
            w_disp_nxt = ~r_disp_on;
          end
        end
      end
      default: begin
        w_state_nxt = S_POWER;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_start) begin
      w_state_nxt  = S_C0;
      w_half_nxt   = 1'b0;
      w_single_nxt = w_ld[9];
      w_rs_nxt     = w_ld[8];
      w_byte_nxt   = w_ld[7:0];
      w_dout_nxt   = w_ld[7:4];
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state    <= S_POWER;
      r_cnt      <= '0;
      r_step     <= '0;
      r_byte     <= '0;
      r_single   <= 1'b0;
      r_half     <= 1'b0;
      r_fx       <= 1'b0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_disp_on  <= 1'b0;
      r_rs       <= 1'b0;
      r_e        <= 1'b0;
      r_dout     <= '0;
      r_led0     <= 1'b0;
      r_led1     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step     <= w_step_nxt;
      r_byte     <= w_byte_nxt;
      r_single   <= w_single_nxt;
      r_half     <= w_half_nxt;
      r_fx       <= w_fx_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_disp_on  <= w_disp_nxt;
      r_rs       <= w_rs_nxt;
      r_e        <= w_e_nxt;
      r_dout     <= w_dout_nxt;
      r_led0     <= w_led0_nxt;
      r_led1     <= w_led1_nxt;
    end
  end

  assign io_out = {r_led1, r_led0, r_dout, r_e, r_rs};

endmodule
`default_nettype wire

// File: tb/tb_tholin_namebadge.sv
`default_nettype none
// ============================================================================
// tb_tholin_namebadge - randomized self-checking bench for tholin_namebadge | rev 1.0
// ============================================================================
module tb_tholin_namebadge;

  localparam int P_POWER = 10;
  localparam int P_INIT  = 2;
  localparam int P_BYTE  = 2;
  localparam int P_CLEAR = 3;
  localparam int P_TICK  = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [1:0] ef   = 2'b00;
  logic [3:0] junk = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {junk, ef, rst, clk};

  tholin_namebadge #(
    .POWERUP_CYCLES   (P_POWER),
    .INIT_WAIT_CYCLES (P_INIT),
    .BYTE_WAIT_CYCLES (P_BYTE),
    .CLEAR_WAIT_CYCLES(P_CLEAR),
    .TICK_CYCLES      (P_TICK)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];   // expected {RS, nibble} stream for init + message
  logic [4:0] cap_q[$];   // captured {RS, nibble} while E is high
  logic [7:0] fx_exp[$];  // expected effect command bytes
  bit         e_prev    = 1'b0;
  bit         led1_prev = 1'b0;
  bit         fx_on     = 1'b0;
  bit         md_on     = 1'b0;  // model: display currently on
  int         long_e    = 0;
  int         unstable  = 0;
  int         toggles   = 0;
  int         cyc       = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endfunction

  function automatic void build_expected();
    string top;
    string bot;
    top = "  HELLO, I AM   ";
    bot = "     THOLIN     ";
    exp_q.delete();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, top[i]);
    push_byte(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) push_byte(1'b1, bot[i]);
  endfunction

  // Effect rules applied once per LED1 toggle, using the pins as they stood.
  function automatic void model_tick(input logic [1:0] m);
    if (m != 2'b10 && !md_on) begin
      fx_exp.push_back(8'h0C);
      md_on = 1'b1;
    end
    case (m)
      2'b01: fx_exp.push_back(8'h18);
      2'b11: fx_exp.push_back(8'h1C);
      2'b10: begin
        fx_exp.push_back(md_on ? 8'h08 : 8'h0C);
        md_on = !md_on;
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (io_out[1]) begin
      if (e_prev) long_e++;
      cap_q.push_back({io_out[0], io_out[5:2]});
    end else if (e_prev) begin
      if ({io_out[0], io_out[5:2]} != cap_q[$]) unstable++;
    end
    e_prev = io_out[1];
    if (io_out[7] != led1_prev) begin
      toggles++;
      if (fx_on) model_tick(ef);
    end
    led1_prev = io_out[7];
    junk = 4'($urandom);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, "_async"}, 32'(io_out), 32'h0);
    repeat (5) @(negedge clk);
    check_eq({tag, "_hold"}, 32'(io_out), 32'h0);
    rst = 1'b0;
    cap_q.delete();
    e_prev    = 1'b0;
    led1_prev = 1'b0;
    long_e    = 0;
    unstable  = 0;
    fx_on     = 1'b0;
  endtask

  task automatic check_boot(input string tag);
    int quiet;
    bit seen;
    bit led0_last;
    int n;
    quiet = 0;
    seen  = 1'b0;
    for (int i = 0; i < P_POWER + 20 && !seen; i++) begin
      tick();
      if (io_out[1]) seen = 1'b1;
      else quiet++;
    end
    check_eq({tag, "_power_wait"}, 32'(quiet), 32'(P_POWER));
    for (int i = 0; i < 3000 && cap_q.size() < exp_q.size(); i++) tick();
    led0_last = io_out[6];
    check_eq({tag, "_nibble_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_nib%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_led0_before"}, 32'(led0_last), 32'h0);
    for (int i = 0; i < 50 && !io_out[6]; i++) tick();
    check_eq({tag, "_led0_after"}, 32'(io_out[6]), 32'h1);
    check_eq({tag, "_e_one_cycle"}, 32'(long_e), 32'h0);
    check_eq({tag, "_dout_stable"}, 32'(unstable), 32'h0);
  endtask

  task automatic run_mode(input logic [1:0] m, input int n, input bit quiet);
    int t0;
    int sz0;
    int c0;
    bit first;
    ef    = m;
    t0    = toggles;
    sz0   = 0;
    c0    = 0;
    first = 1'b1;
    for (int i = 0; i < n * (P_TICK + 40) && toggles < t0 + n; i++) begin
      tick();
      if (first && toggles == t0 + 1) begin
        first = 1'b0;
        sz0   = cap_q.size();
        c0    = cyc;
      end
    end
    check_eq($sformatf("ticks_mode%0d", m), 32'(toggles - t0), 32'(n));
    if (quiet) begin
      check_eq("static_no_e", 32'(cap_q.size() - sz0), 32'h0);
      check_eq("static_period", 32'((cyc - c0 >= P_TICK) && (cyc - c0 <= P_TICK + 2)), 32'h1);
    end
  endtask

  task automatic check_effects();
    int nb;
    check_eq("fx_nibble_count", 32'(cap_q.size()), 32'(2 * fx_exp.size()));
    nb = cap_q.size() / 2;
    if (nb > fx_exp.size()) nb = fx_exp.size();
    for (int i = 0; i < nb; i++)
      check_eq($sformatf("fx_byte%0d", i),
               32'({cap_q[2*i][4], cap_q[2*i+1][4], cap_q[2*i][3:0], cap_q[2*i+1][3:0]}),
               32'({2'b00, fx_exp[i]}));
  endtask

  initial begin
    build_expected();
    #2;
    do_reset("reset");
    check_boot("boot");

    cap_q.delete();
    fx_exp.delete();
    md_on = 1'b1;
    fx_on = 1'b1;
    run_mode(2'b01, 2, 1'b0);
    run_mode(2'b11, 2, 1'b0);
    run_mode(2'b00, 2, 1'b1);
    run_mode(2'b10, 3, 1'b0);
    run_mode(2'b01, 2, 1'b0);
    for (int k = 0; k < 6; k++)
      run_mode(2'($urandom_range(0, 3)), int'($urandom_range(1, 2)), 1'b0);
    run_mode(2'b00, 2, 1'b0);
    check_effects();
    check_eq("led0_held", 32'(io_out[6]), 32'h1);

    ef = 2'b00;
    do_reset("reset2");
    for (int i = 0; i < 3000 && cap_q.size() < 17; i++) tick();
    check_eq("mid_is_data_hi", 32'({io_out[1], io_out[0]}), 32'h3);
    do_reset("mid_reset");
    check_boot("reboot");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
